// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and constants for the RV32I hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

  localparam int REG_X0 = 0;

endpackage
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : forward_unit
// Purpose  : EX-operand bypass select for one source register; MEM beats WB.
// Revision : 1.0 - initial release
// ============================================================================
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  output fwd_sel_t          fwd_o
);

  localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_X0);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != X0) && (rd_m_i == rs_e_i))
      fwd_o = FWD_MEM;
    else if (reg_write_w_i && (rd_w_i != X0) && (rd_w_i == rs_e_i))
      fwd_o = FWD_WB;
  end

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : Stall/flush/forward sequencing and dmem handshake for the 5-stage
//            core. Optional perf counters enabled by macro HAZARD_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int          REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef HAZARD_PERF_EN
  ,
  parameter int          CNT_W       = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic [1:0]        result_src_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              pc_src_e,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  output logic              dmem_valid,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_lw_stall,
  output logic [CNT_W-1:0]  perf_flush,
  output logic [CNT_W-1:0]  perf_mem_wait
`endif
);

  localparam logic [REG_AW-1:0] X0        = REG_AW'(REG_X0);
  localparam logic [15:0]       TIMEOUT_C = 16'(MEM_TIMEOUT);

  mem_state_t  state_q;
  logic [15:0] wait_cnt_q;
  logic        mem_err_q;
  logic        rst_q;

  logic     hold, lw_stall, mem_stall, valid_raw;
  fwd_sel_t fwd_a, fwd_b;
  logic     unused_ok;

  assign unused_ok = result_src_e[1];

  forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e_i(rs1_e), .rd_m_i(rd_m), .rd_w_i(rd_w),
    .reg_write_m_i(reg_write_m), .reg_write_w_i(reg_write_w), .fwd_o(fwd_a)
  );

  forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e_i(rs2_e), .rd_m_i(rd_m), .rd_w_i(rd_w),
    .reg_write_m_i(reg_write_m), .reg_write_w_i(reg_write_w), .fwd_o(fwd_b)
  );

  // Outputs are pinned to the bubble pattern while reset is high and for one cycle after.
  assign hold = reset | rst_q;

  assign lw_stall = result_src_e[0] && (rd_e != X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_comb begin
    valid_raw = 1'b0;
    case (state_q)
      IDLE:    valid_raw = dmem_req_m;
      WAIT:    valid_raw = 1'b1;
      default: valid_raw = 1'b0;
    endcase
  end

  assign dmem_valid = valid_raw & ~hold;
  assign mem_stall  = (dmem_valid & ~dmem_ready) | (state_q == ERR);
  assign mem_err    = mem_err_q & ~reset;
  assign fwd_a_e    = hold ? FWD_RF : fwd_a;
  assign fwd_b_e    = hold ? FWD_RF : fwd_b;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (hold) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall) begin
      // EX is frozen, so any pending redirect or load-use is seen again after release.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dmem_valid && !dmem_ready) begin
            state_q    <= WAIT;
            wait_cnt_q <= 16'd1;
          end else begin
            wait_cnt_q <= '0;
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q >= TIMEOUT_C) begin
            state_q   <= ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        ERR:     mem_err_q <= 1'b1;
        default: state_q   <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_lw_q, perf_flush_q, perf_mem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lw_q    <= '0;
      perf_flush_q <= '0;
      perf_mem_q   <= '0;
    end else if (!hold) begin
      if (lw_stall && (perf_lw_q != '1))
        perf_lw_q <= perf_lw_q + 1'b1;
      if (pc_src_e && !mem_stall && (perf_flush_q != '1))
        perf_flush_q <= perf_flush_q + 1'b1;
      if (mem_stall && (perf_mem_q != '1))
        perf_mem_q <= perf_mem_q + 1'b1;
    end
  end

  assign perf_lw_stall = perf_lw_q;
  assign perf_flush    = perf_flush_q;
  assign perf_mem_wait = perf_mem_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Purpose  : Vector table plus multi-cycle sequences for hazard_controller.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_controller;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]    result_src_e;
  logic          reg_write_m, reg_write_w, pc_src_e, dmem_req_m, dmem_ready;
  logic          dmem_valid, stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w, mem_err;
  logic [1:0]    fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_EN
  logic [31:0]   perf_lw_stall, perf_flush, perf_mem_wait;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_controller #(
    .REG_AW(AW), .MEM_TIMEOUT(4)
`ifdef HAZARD_PERF_EN
    , .CNT_W(32)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .result_src_e(result_src_e),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready), .dmem_valid(dmem_valid),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .perf_lw_stall(perf_lw_stall), .perf_flush(perf_flush), .perf_mem_wait(perf_mem_wait)
`endif
  );

  // Expected word: {sf,sd,se,sm, fd,fe,fw, fwd_a[1:0], fwd_b[1:0], dmem_valid, mem_err}
  localparam logic [12:0] E_Z   = 13'b0000_000_00_00_0_0;
  localparam logic [12:0] E_RST = 13'b0000_111_00_00_0_0;
  localparam logic [12:0] E_MS  = 13'b1111_001_00_00_1_0;
  localparam logic [12:0] E_ERR = 13'b1111_001_00_00_0_1;
  localparam logic [12:0] E_LW  = 13'b1100_010_00_00_0_0;
  localparam logic [12:0] E_CF  = 13'b0000_110_00_00_0_0;
  localparam logic [12:0] E_V   = 13'b0000_000_00_00_1_0;

  typedef struct {
    string         name;
    logic [AW-1:0] r1d, r2d, r1e, r2e, rde, rdm, rdw;
    logic [1:0]    rsrc;
    logic          rwm, rww, pc, req, rdy;
    logic [12:0]   exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [12:0] exp;
  } sb_t;

  sb_t sb_q[$];

  function automatic vec_t mkv(string n, int r1d, int r2d, int r1e, int r2e, int rde,
                               int rdm, int rdw, int rsrc, bit rwm, bit rww, bit pc,
                               bit req, bit rdy, logic [12:0] e);
    vec_t v;
    v.name = n;
    v.r1d = AW'(r1d); v.r2d = AW'(r2d); v.r1e = AW'(r1e); v.r2e = AW'(r2e);
    v.rde = AW'(rde); v.rdm = AW'(rdm); v.rdw = AW'(rdw); v.rsrc = 2'(rsrc);
    v.rwm = rwm; v.rww = rww; v.pc = pc; v.req = req; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue the expectation, compare at the falling edge.
  task automatic run(input vec_t v);
    sb_t         s;
    logic [12:0] act;
    rs1_d = v.r1d; rs2_d = v.r2d; rs1_e = v.r1e; rs2_e = v.r2e;
    rd_e = v.rde; rd_m = v.rdm; rd_w = v.rdw; result_src_e = v.rsrc;
    reg_write_m = v.rwm; reg_write_w = v.rww; pc_src_e = v.pc;
    dmem_req_m = v.req; dmem_ready = v.rdy;
    sb_q.push_back('{v.name, v.exp});
    @(negedge clk);
    s   = sb_q.pop_front();
    act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           fwd_a_e, fwd_b_e, dmem_valid, mem_err};
    tests++;
    if (act !== s.exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", s.name, act, s.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string n, input logic [12:0] e);
    run(mkv(n, 0,0,0,0,0,0,0, 0, 0,0,0,0,0, e));
  endtask

  task automatic mreq(input string n, input bit rdy, input logic [12:0] e);
    run(mkv(n, 0,0,0,0,0,0,0, 0, 0,0,0,1,rdy, e));
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mkv("zero",          0,0,0,0,0,0,0, 0, 0,0,0,0,0, E_Z));
    tbl.push_back(mkv("fwd_a_mem",     0,0,5,0,0,5,0, 0, 1,0,0,0,0, 13'b0000_000_10_00_0_0));
    tbl.push_back(mkv("fwd_mem_prio",  0,0,5,0,0,5,5, 0, 1,1,0,0,0, 13'b0000_000_10_00_0_0));
    tbl.push_back(mkv("fwd_x0",        0,0,0,0,0,0,0, 0, 1,1,0,0,0, E_Z));
    tbl.push_back(mkv("fwd_b_wb",      0,0,0,7,0,0,7, 0, 0,1,0,0,0, 13'b0000_000_00_01_0_0));
    tbl.push_back(mkv("fwd_mix",       0,0,4,3,0,3,4, 0, 1,1,0,0,0, 13'b0000_000_01_10_0_0));
    tbl.push_back(mkv("fwd_no_wen",    0,0,5,0,0,5,0, 0, 0,0,0,0,0, E_Z));
    tbl.push_back(mkv("lw_rs2",        0,6,0,0,6,0,0, 1, 0,0,0,0,0, E_LW));
    tbl.push_back(mkv("lw_rs1",        6,0,0,0,6,0,0, 1, 0,0,0,0,0, E_LW));
    tbl.push_back(mkv("lw_x0",         0,0,0,0,0,0,0, 1, 0,0,0,0,0, E_Z));
    tbl.push_back(mkv("nonload_dep",   6,0,0,0,6,0,0, 2, 0,0,0,0,0, E_Z));
    tbl.push_back(mkv("pc_src",        0,0,0,0,0,0,0, 0, 0,0,1,0,0, E_CF));
    tbl.push_back(mkv("pc_src_lw",     0,6,0,0,6,0,0, 1, 0,0,1,0,0, E_CF));
    tbl.push_back(mkv("mem_ready",     0,0,0,0,0,0,0, 0, 0,0,0,1,1, E_V));

    // Forwarding-provoking inputs must still read as the reset pattern.
    reset = 1'b1;
    run(mkv("rst_hold",  0,0,5,5,0,5,5, 0, 1,1,0,1,0, E_RST));
    reset = 1'b0;
    run(mkv("rst_after", 0,0,5,5,0,5,5, 0, 1,1,0,1,0, E_RST));

    foreach (tbl[i]) run(tbl[i]);

    run(mkv("lw_seq_stall", 0,6,0,0,6,0,0, 1, 0,0,0,0,0, E_LW));
    idle("lw_seq_release", E_Z);

    mreq("wait_c0", 1'b0, E_MS);
    run(mkv("wait_c1_pc_masked", 0,6,0,0,6,0,0, 1, 0,0,1,1,0, E_MS));
    run(mkv("wait_c2_fwd",       0,0,5,0,0,5,0, 0, 1,0,0,1,0, 13'b1111_001_10_00_1_0));
    mreq("wait_done", 1'b1, E_V);
    idle("wait_idle_after", E_Z);

    for (int c = 0; c < 5; c++) mreq($sformatf("to_wait%0d", c), 1'b0, E_MS);
    mreq("to_err", 1'b0, E_ERR);
    idle("err_sticky", E_ERR);
    mreq("err_ready_ignored", 1'b1, E_ERR);
    reset = 1'b1;
    idle("err_reset", E_RST);
    reset = 1'b0;
    idle("err_reset_after", E_RST);
    idle("err_cleared", E_Z);

    mreq("rw_c0", 1'b0, E_MS);
    mreq("rw_c1", 1'b0, E_MS);
    reset = 1'b1;
    mreq("rw_reset", 1'b0, E_RST);
    reset = 1'b0;
    idle("rw_after", E_RST);
    idle("rw_idle", E_Z);
    mreq("rw_fresh_access", 1'b1, E_V);

`ifdef HAZARD_PERF_EN
    run(mkv("perf_lw1", 0,6,0,0,6,0,0, 1, 0,0,0,0,0, E_LW));
    idle("perf_gap", E_Z);
    run(mkv("perf_lw2", 6,0,0,0,6,0,0, 1, 0,0,0,0,0, E_LW));
    run(mkv("perf_pc",  0,0,0,0,0,0,0, 0, 0,0,1,0,0, E_CF));
    for (int c = 0; c < 3; c++) mreq($sformatf("perf_wait%0d", c), 1'b0, E_MS);
    mreq("perf_done", 1'b1, E_V);
    tests++;
    if (perf_lw_stall !== 32'd2) begin
      fails++; $display("FAIL perf_lw_stall: got %0d expected 2", perf_lw_stall);
    end
    tests++;
    if (perf_flush !== 32'd1) begin
      fails++; $display("FAIL perf_flush: got %0d expected 1", perf_flush);
    end
    tests++;
    if (perf_mem_wait !== 32'd3) begin
      fails++; $display("FAIL perf_mem_wait: got %0d expected 3", perf_mem_wait);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
